fm_bank_ctrl: RTL

Controller that sequences the double-buffered feature-memory (FM) RAM. It accepts a byte stream from the producer with a valid/ready handshake and fills banks in turn. It hands each full bank to the consumer as a burst of wide reads, `READ_ADDRESSES_COUNT` bytes per beat, and returns a bank to the writer only after its last read. It sits between the MinHash front end, the FM storage array and the downstream hashing stage, and it drives the storage array's write and read ports directly.

---
 rtl/fm_pkg.sv | 42 ++++
 rtl/fm_bank_ptr.sv | 56 +++++
 rtl/fm_bank_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// Shared types and elaboration helpers for the
// double-buffered feature-memory controller.
package fm_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  function automatic int buffer_size(
    input int rams,
    input int entries,
    input int offset
  );
    return rams * entries * offset;
  endfunction

  function automatic int addr_bits(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int bank_bits(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(
    input int count,
    input int size,
    input int rac
  );
    return is_pow2(count) && (count >= 2) &&
           is_pow2(rac) && (rac <= size) &&
           ((size % rac) == 0);
  endfunction

endpackage

// File: rtl/fm_bank_ptr.sv
// Bank/address pointer: steps within a bank and
// wraps to the next bank at the end-of-bank compare.
module fm_bank_ptr
  import fm_pkg::*;
#(
  parameter int unsigned STEP       = 1,
  parameter int unsigned LIMIT      = 64,
  parameter int unsigned BANK_COUNT = 2,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned BANK_W     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              adv_i,
  output logic [BANK_W-1:0] bank_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LIMIT - STEP);
  localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(BANK_COUNT - 1);

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign bank_o = bank_q;
  assign addr_o = addr_q;
  assign last_o = (addr_q == LAST_A);

  // Wrap only through the explicit compare, never overflow
  always_comb begin
    bank_d = bank_q;
    addr_d = addr_q;
    if (adv_i) begin
      if (last_o) begin
        addr_d = '0;
        bank_d = (bank_q == BANK_MAX) ? '0
               : bank_q + BANK_W'(1);
      end else begin
        addr_d = addr_q + STEP_A;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q <= '0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/fm_bank_ctrl.sv
// Sequences FM banks: fills from the byte stream,
// drains full banks as wide read beats, in index order.
module fm_bank_ctrl
  import fm_pkg::*;
#(
  parameter int BUFFER_COUNT         = 2,
  parameter int RAMS                 = 2,
  parameter int ENTRIES              = 4,
  parameter int OFFSET               = 8,
  parameter int DATA_BITS            = 8,
  parameter int READ_ADDRESSES_COUNT = 2,
  localparam int BUFFER_SIZE = buffer_size(RAMS, ENTRIES, OFFSET),
  localparam int ADDR_BITS   = addr_bits(BUFFER_SIZE),
  localparam int BANK_BITS   = bank_bits(BUFFER_COUNT)
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_wvalid,
  input  logic [DATA_BITS-1:0] in_wdata,
  output logic                 out_wready,
  output logic                 out_mem_we,
  output logic [BANK_BITS-1:0] out_mem_wbank,
  output logic [ADDR_BITS-1:0] out_mem_waddr,
  output logic [DATA_BITS-1:0] out_mem_wdata,
  input  logic                 in_rready,
  output logic                 out_mem_re,
  output logic [BANK_BITS-1:0] out_mem_rbank,
  output logic [ADDR_BITS-1:0] out_mem_raddr,
  output logic                 out_rvalid,
  output logic                 out_rlast,
  output logic [BANK_BITS:0]   out_full_banks
);

  if (!params_ok(BUFFER_COUNT, BUFFER_SIZE,
                 READ_ADDRESSES_COUNT)) begin : g_bad_params
    $error("fm_bank_ctrl: invalid bank parameters");
  end

  bank_state_t state_q [BUFFER_COUNT];
  bank_state_t state_d [BUFFER_COUNT];

  logic [BANK_BITS:0]   full_q, full_d;
  logic                 rvalid_q, rlast_q;
  logic [BANK_BITS-1:0] wbank, rbank;
  logic [ADDR_BITS-1:0] waddr, raddr;
  logic                 w_at_end, r_at_end;
  logic                 we, re, wlast, rlast;
  bank_state_t          wstate, rstate;

  fm_bank_ptr #(
    .STEP       (1),
    .LIMIT      (BUFFER_SIZE),
    .BANK_COUNT (BUFFER_COUNT),
    .ADDR_W     (ADDR_BITS),
    .BANK_W     (BANK_BITS)
  ) u_wptr (
    .clk_i  (in_clk),
    .rst_i  (in_rst),
    .adv_i  (we),
    .bank_o (wbank),
    .addr_o (waddr),
    .last_o (w_at_end)
  );

  fm_bank_ptr #(
    .STEP       (READ_ADDRESSES_COUNT),
    .LIMIT      (BUFFER_SIZE),
    .BANK_COUNT (BUFFER_COUNT),
    .ADDR_W     (ADDR_BITS),
    .BANK_W     (BANK_BITS)
  ) u_rptr (
    .clk_i  (in_clk),
    .rst_i  (in_rst),
    .adv_i  (re),
    .bank_o (rbank),
    .addr_o (raddr),
    .last_o (r_at_end)
  );

  assign wstate = state_q[wbank];
  assign rstate = state_q[rbank];

  assign out_wready = (wstate == EMPTY) ||
                      (wstate == FILLING);
  assign we    = in_wvalid & out_wready;
  assign wlast = we & w_at_end;
  assign re    = in_rready &
                 ((rstate == FULL) || (rstate == DRAINING));
  assign rlast = re & r_at_end;

  assign out_mem_we     = we;
  assign out_mem_wbank  = wbank;
  assign out_mem_waddr  = waddr;
  assign out_mem_wdata  = in_wdata;
  assign out_mem_re     = re;
  assign out_mem_rbank  = rbank;
  assign out_mem_raddr  = raddr;
  assign out_rvalid     = rvalid_q;
  assign out_rlast      = rlast_q;
  assign out_full_banks = full_q;

  // Write and read never target the same bank in one cycle
  always_comb begin
    for (int i = 0; i < BUFFER_COUNT; i++) begin
      state_d[i] = state_q[i];
    end
    if (we) begin
      state_d[wbank] = wlast ? FULL : FILLING;
    end
    if (re) begin
      state_d[rbank] = rlast ? EMPTY : DRAINING;
    end
  end

  always_comb begin
    full_d = full_q;
    unique case (1'b1)
      wlast && !rlast: full_d = full_q + (BANK_BITS+1)'(1);
      rlast && !wlast: full_d = full_q - (BANK_BITS+1)'(1);
      default:         full_d = full_q;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < BUFFER_COUNT; i++) begin
        state_q[i] <= EMPTY;
      end
      full_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      for (int i = 0; i < BUFFER_COUNT; i++) begin
        state_q[i] <= state_d[i];
      end
      full_q   <= full_d;
      rvalid_q <= re;
      rlast_q  <= rlast;
    end
  end

endmodule
